// File: rtl/lcd_text_writer_if.sv
// Processor-side bus of the LCD text writer: buffer write port, start
// request with length, 4-bit LCD pins and busy/done status.
interface lcd_text_writer_if #(
  parameter int DEPTH = 32
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              iWriteEnable;
  logic [ADDR_W-1:0] iWriteAddr;
  logic [7:0]        iWriteData;
  logic              iStart;
  logic [7:0]        iLength;
  logic [3:0]        oLCD_Data;
  logic              oLCD_RS;
  logic              oLCD_E;
  logic              oLCD_RW;
  logic              oBusy;
  logic              oDone;

  // Processor / bench side.
  modport master (
    output iWriteEnable, iWriteAddr, iWriteData, iStart, iLength,
    input  oLCD_Data, oLCD_RS, oLCD_E, oLCD_RW, oBusy, oDone
  );

  // Text writer side.
  modport slave (
    input  iWriteEnable, iWriteAddr, iWriteData, iStart, iLength,
    output oLCD_Data, oLCD_RS, oLCD_E, oLCD_RW, oBusy, oDone
  );
endinterface

// File: rtl/lcd_text_writer.sv
// String sequencer for the Spartan-3E character LCD in 4-bit mode.
// Streams len buffered bytes as upper/lower nibble pairs, each nibble going
// through SETUP -> PULSE (E high) -> HOLD -> GAP. Byte 8'h0A becomes the
// "cursor to line 2" command 8'hC0 with RS = 0. Every *_CYCLES parameter
// is expected to be at least 1 and below 2**CNT_W; DEPTH is a power of two
// between 2 and 256.
module lcd_text_writer #(
  parameter int DEPTH             = 32,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int CHAR_GAP_CYCLES   = 2000,
  parameter int CNT_W             = 16
) (
  input  logic               clk,
  input  logic               rst,
  lcd_text_writer_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Terminal counter values: a state lasting N cycles counts 0 .. N-1.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] NGAP_LAST  = CNT_W'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CGAP_LAST  = CNT_W'(CHAR_GAP_CYCLES - 1);
  localparam logic [8:0]       DEPTH_LEN  = 9'(DEPTH);

  // Character buffer.
  logic [7:0] mem_q [DEPTH];

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       idx_q, idx_d;
  logic [8:0]       len_q, len_d;
  logic             lower_q, lower_d;
  logic [3:0]       low_nib_q, low_nib_d;
  logic [3:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [8:0]        len_req;
  logic [8:0]        idx_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic [8:0]        fetched;
  logic [CNT_W-1:0]  cur_last;
  logic              at_last;

  // Returns {rs, code} for one buffer byte; newline moves to line 2.
  function automatic logic [8:0] map_char(input logic [7:0] b);
    if (b == 8'h0A) return {1'b0, 8'hC0};
    return {1'b1, b};
  endfunction

  // Buffer write port, open in every state.
  // NOTE: the buffer has no reset branch; text survives rst and this lets
  // the array map onto plain RAM instead of a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (bus.iWriteEnable) mem_q[bus.iWriteAddr] <= bus.iWriteData;
  end

  assign len_req    = ({1'b0, bus.iLength} > DEPTH_LEN) ? DEPTH_LEN : {1'b0, bus.iLength};
  assign idx_next   = idx_q + 9'd1;
  // In IDLE the byte to fetch is entry 0, otherwise the next character.
  assign fetch_addr = (state_q == ST_IDLE) ? '0 : idx_next[ADDR_W-1:0];
  assign fetched    = map_char(mem_q[fetch_addr]);
  assign at_last    = (cnt_q == cur_last);

  // Selects the terminal count of the current timing phase.
  always_comb begin
    cur_last = '0;
    case (state_q)
      ST_SETUP: cur_last = SETUP_LAST;
      ST_PULSE: cur_last = PULSE_LAST;
      ST_HOLD:  cur_last = HOLD_LAST;
      ST_GAP:   cur_last = lower_q ? CGAP_LAST : NGAP_LAST;
      default:  cur_last = '0;
    endcase
  end

  // Next-state logic for the nibble sequencer.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path can leave a signal unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    lower_d   = lower_q;
    low_nib_d = low_nib_q;
    data_d    = data_q;
    rs_d      = rs_q;
    e_d       = e_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != ST_IDLE) cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          if (len_req == 9'd0) begin
            done_d = 1'b1;
          end else begin
            len_d                     = len_req;
            idx_d                     = '0;
            lower_d                   = 1'b0;
            {rs_d, data_d, low_nib_d} = fetched;
            busy_d                    = 1'b1;
            cnt_d                     = '0;
            state_d                   = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (at_last) begin
          e_d     = 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (at_last) begin
          e_d     = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (at_last) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (at_last) begin
          if (!lower_q) begin
            lower_d = 1'b1;
            data_d  = low_nib_q;
            state_d = ST_SETUP;
          end else if (idx_q == len_q - 9'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d                     = idx_next;
            lower_d                   = 1'b0;
            {rs_d, data_d, low_nib_d} = fetched;
            state_d                   = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears E asynchronously.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      lower_q   <= 1'b0;
      low_nib_q <= '0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      lower_q   <= lower_d;
      low_nib_q <= low_nib_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      e_q       <= e_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.oLCD_Data = data_q;
  assign bus.oLCD_RS   = rs_q;
  assign bus.oLCD_E    = e_q;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer. The stimulus side computes, from a
// snapshot of the text and the timing rules, every E pulse (start cycle,
// nibble, RS) and the done cycle / busy length of each accepted transfer;
// two monitors pop and compare as the DUT produces pulses and done strobes.
module tb_lcd_text_writer;

  localparam int DEPTH = 8;
  localparam int S     = 2;
  localparam int P     = 3;
  localparam int H     = 1;
  localparam int NG    = 4;
  localparam int CG    = 8;
  localparam int C     = 2 * (S + P + H) + NG + CG;  // 24

  typedef struct {
    int       rise;
    logic [3:0] nib;
    logic     rs;
  } pulse_t;

  typedef struct {
    int at;
    int busy;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_text_writer_if #(.DEPTH(DEPTH)) bus ();

  lcd_text_writer #(
    .DEPTH(DEPTH), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .NIBBLE_GAP_CYCLES(NG), .CHAR_GAP_CYCLES(CG), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pulse_t     exp_q[$];
  done_t      done_q[$];
  logic [7:0] mem_m [DEPTH];
  int         cyc     = 0;
  int         free_at = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: what an accepted start at edge t0 must produce.
  task automatic push_transfer(input int t0, input int len_req);
    int n;
    logic [7:0] b, code;
    logic rs;
    n = (len_req > DEPTH) ? DEPTH : len_req;
    for (int j = 0; j < n; j++) begin
      b    = mem_m[j];
      code = (b == 8'h0A) ? 8'hC0 : b;
      rs   = (b != 8'h0A);
      exp_q.push_back('{t0 + j * C + S, code[7:4], rs});
      exp_q.push_back('{t0 + j * C + (S + P + H + NG) + S, code[3:0], rs});
    end
    done_q.push_back('{t0 + n * C, n * C});
    free_at = t0 + n * C + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic write_buf(input int a, input logic [7:0] d);
    bus.iWriteEnable = 1'b1;
    bus.iWriteAddr   = 3'(a);
    bus.iWriteData   = d;
    step();
    bus.iWriteEnable = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic start(input int len, output int t0);
    bus.iStart  = 1'b1;
    bus.iLength = 8'(len);
    t0 = cyc + 1;
    step();
    bus.iStart = 1'b0;
    if (t0 >= free_at) push_transfer(t0, len);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (done_q.size() != 0 && k < 3000) begin
      step();
      k++;
    end
    check("transfer completed within budget", 32'(done_q.size()), 0);
    repeat (3) step();
    check("no outstanding E pulses", 32'(exp_q.size()), 0);
  endtask

  // E pulse monitor: measures each pulse and compares it to the scoreboard.
  initial begin : pulse_mon
    bit         in_pulse;
    bit         stable;
    int         rise, width;
    logic [3:0] nib;
    logic       rs;
    pulse_t     e;
    in_pulse = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pulse = 0;
        continue;
      end
      if (bus.oLCD_E === 1'b1) begin
        if (!in_pulse) begin
          in_pulse = 1;
          stable   = 1;
          rise     = cyc;
          width    = 1;
          nib      = bus.oLCD_Data;
          rs       = bus.oLCD_RS;
          check("RW low during E", 32'(bus.oLCD_RW), 0);
        end else begin
          width++;
          if (bus.oLCD_Data !== nib || bus.oLCD_RS !== rs) stable = 0;
        end
      end else if (in_pulse) begin
        in_pulse = 0;
        check("E pulse was expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("E rise cycle", rise, e.rise);
          check("nibble", 32'(nib), 32'(e.nib));
          check("RS", 32'(rs), 32'(e.rs));
          check("E width", width, P);
          check("data/RS stable while E high", 32'(stable), 1);
          check("data held after E fall", 32'({bus.oLCD_RS, bus.oLCD_Data}), 32'({rs, nib}));
        end
      end
    end
  end

  // Done monitor: checks done timing and the busy length of the transfer.
  initial begin : done_mon
    int    busy_cnt;
    done_t d;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        continue;
      end
      if (bus.oBusy === 1'b1) busy_cnt++;
      if (bus.oDone === 1'b1) begin
        check("done was expected", 32'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("done cycle", cyc, d.at);
          check("busy cycles", busy_cnt, d.busy);
          check("busy low with done", 32'(bus.oBusy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin : stim
    int t0, t1, k;
    bus.iWriteEnable = 1'b0;
    bus.iWriteAddr   = '0;
    bus.iWriteData   = '0;
    bus.iStart       = 1'b0;
    bus.iLength      = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h20;

    repeat (2) @(posedge clk);
    #1;
    check("reset oLCD_Data", 32'(bus.oLCD_Data), 0);
    check("reset oLCD_RS", 32'(bus.oLCD_RS), 0);
    check("reset oLCD_E", 32'(bus.oLCD_E), 0);
    check("reset oLCD_RW", 32'(bus.oLCD_RW), 0);
    check("reset oBusy", 32'(bus.oBusy), 0);
    check("reset oDone", 32'(bus.oDone), 0);
    rst = 1'b0;
    step();

    // Define the whole buffer so the model and the DUT agree everywhere.
    for (int i = 0; i < DEPTH; i++) write_buf(i, 8'h20);

    // "Hi", two characters.
    write_buf(0, 8'h48);
    write_buf(1, 8'h69);
    start(2, t0);
    wait_idle();

    // Newline in the middle is sent as a command.
    write_buf(0, 8'h41);
    write_buf(1, 8'h0A);
    write_buf(2, 8'h42);
    start(3, t0);
    wait_idle();

    // Zero length: done only.
    start(0, t0);
    wait_idle();

    // Length beyond DEPTH is clamped.
    for (int i = 0; i < DEPTH; i++) write_buf(i, 8'($urandom_range(32'h21, 32'h7E)));
    start(20, t0);
    wait_idle();

    // Starts while busy are ignored; a late write does not touch the byte in flight.
    write_buf(0, 8'h48);
    write_buf(1, 8'h69);
    start(2, t0);
    wait_until(t0 + 4);
    write_buf(0, 8'h5A);
    wait_until(t0 + 9);
    start(2, t1);
    wait_until(t0 + 29);
    start(7, t1);
    wait_idle();

    // Back-to-back: start accepted on the cycle after done.
    start(1, t0);
    wait_until(t0 + C);
    start(2, t1);
    wait_idle();

    // Reset while E is high, then restart from index 0 with retained text.
    start(2, t0);
    k = 0;
    while (bus.oLCD_E !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("E high before reset", 32'(bus.oLCD_E), 1);
    #2;
    rst = 1'b1;
    #1;
    check("E drops on reset", 32'(bus.oLCD_E), 0);
    check("data cleared on reset", 32'(bus.oLCD_Data), 0);
    check("RS cleared on reset", 32'(bus.oLCD_RS), 0);
    check("busy cleared on reset", 32'(bus.oBusy), 0);
    check("done clear on reset", 32'(bus.oDone), 0);
    check("RW low on reset", 32'(bus.oLCD_RW), 0);
    exp_q.delete();
    done_q.delete();
    free_at = 0;
    step();
    rst = 1'b0;
    step();
    start(3, t0);
    wait_idle();

    // Randomized text and lengths.
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        write_buf(int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
      end
      start(int'($urandom_range(0, 11)), t0);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
